// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch controller states: issue, await data, present to decode, discard.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  // Default first fetch address after reset.
  localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;

  // Instruction word width.
  localparam int ILEN = 32;

endpackage
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Instruction-fetch stage. Owns the PC, issues one outstanding
//               word read at a time and hands each fetched instruction with
//               its PC to decode over valid/ready. Redirects from execute
//               flush any in-flight or held instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 64,
  parameter logic [XLEN-1:0]  PC_RESET = XLEN'(PC_RESET_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            ireq_addr_ok,
  input  logic            iresp_data_ok,
  input  logic [ILEN-1:0] iresp_data,
  output logic            instr_valid,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [ILEN-1:0] r_instr;
  logic [ILEN-1:0] w_instr_nxt;
  logic [XLEN-1:0] r_instr_pc;
  logic [XLEN-1:0] w_instr_pc_nxt;
  logic            r_instr_valid;
  logic            w_instr_valid_nxt;
  logic [XLEN-1:0] w_redirect_pc;

  // Redirect targets are forced onto a word boundary.
  assign w_redirect_pc = redirect_pc & ~XLEN'(3);

  assign ireq_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

  // Next-state, next-PC and output-buffer update; redirect wins in every state.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;
    ireq_valid        = 1'b0;

    case (r_state)
      REQ: begin
        ireq_valid = 1'b1;
        if (redirect_valid) begin
          // An accepted address is now stale; its response must be dropped.
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = ireq_addr_ok ? DROP : REQ;
        end else if (ireq_addr_ok) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = iresp_data_ok ? REQ : DROP;
        end else if (iresp_data_ok) begin
          w_instr_nxt       = iresp_data;
          w_instr_pc_nxt    = r_pc;
          w_instr_valid_nxt = 1'b1;
          w_pc_nxt          = r_pc + XLEN'(4);
          w_state_nxt       = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_instr_valid_nxt = 1'b0;
          w_pc_nxt          = w_redirect_pc;
          w_state_nxt       = REQ;
        end else if (instr_ready) begin
          w_instr_valid_nxt = 1'b0;
          w_state_nxt       = REQ;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redirect_pc;
        end
        if (iresp_data_ok) begin
          w_state_nxt = REQ;
        end
      end
      default: begin
        w_state_nxt = REQ;
      end
    endcase
  end

  // State, PC and output buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= REQ;
      r_pc          <= PC_RESET;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
    end
  end

  // Only one read is ever outstanding: a response is legal only in WAIT or DROP.
  assert property (@(posedge clk) disable iff (!reset)
                   !(iresp_data_ok && (r_state == REQ || r_state == HOLD)));

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Self-checking bench for ifu_fetch. Acts as instruction bus and
//               decode; compares the DUT every cycle against a transaction
//               model (outstanding-request queue plus held instruction).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

  localparam int          XLEN = 64;
  localparam logic [63:0] PCR  = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_addr_ok = 1'b0;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;

  ifu_fetch #(.XLEN(XLEN), .PC_RESET(PCR)) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .ireq_addr_ok  (ireq_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  // Reference model: next fetch address, reads in flight, instruction held.
  typedef struct packed {
    logic [63:0] addr;
    logic        stale;
  } req_t;

  req_t        q[$];
  logic [63:0] m_pc  = PCR;
  logic        m_hv  = 1'b0;
  logic [31:0] m_hd  = '0;
  logic [63:0] m_hpc = '0;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    logic        exp_req;
    logic [63:0] old_pc;
    req_t        e;
    exp_req = (q.size() == 0) && !m_hv;
    old_pc  = m_pc;
    if (!reset) begin
      m_pc = PCR; m_hv = 1'b0; m_hd = '0; m_hpc = '0;
      q.delete();
      return;
    end
    if (redirect_valid) begin
      m_pc = redirect_pc & ~64'h3;
      m_hv = 1'b0;
      foreach (q[i]) q[i].stale = 1'b1;
    end else if (m_hv && instr_ready) begin
      m_hv = 1'b0;
    end
    if (iresp_data_ok && q.size() > 0) begin
      e = q.pop_front();
      if (!e.stale) begin
        m_hv  = 1'b1;
        m_hd  = iresp_data;
        m_hpc = e.addr;
        m_pc  = e.addr + 64'd4;
      end
    end
    if (exp_req && ireq_addr_ok) q.push_back('{addr: old_pc, stale: redirect_valid});
  endtask

  task automatic check_outputs();
    logic exp_req;
    exp_req = (q.size() == 0) && !m_hv;
    chk("ireq_valid", {63'd0, ireq_valid}, {63'd0, exp_req});
    if (exp_req) chk("ireq_addr", ireq_addr, m_pc);
    chk("instr_valid", {63'd0, instr_valid}, {63'd0, m_hv});
    chk("instr", {32'd0, instr}, {32'd0, m_hd});
    chk("instr_pc", instr_pc, m_hpc);
  endtask

  // Apply one cycle of inputs, clock, update the model and compare.
  task automatic cyc(input logic rn, input logic a, input logic d, input logic r,
                     input logic rv, input logic [63:0] rpc, input logic [31:0] data);
    reset          = rn;
    ireq_addr_ok   = a;
    iresp_data_ok  = d;
    instr_ready    = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    iresp_data     = data;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  initial begin
    logic        a, d, r, rv, rn;
    logic [63:0] rpc;

    // Reset for two cycles, then check reset values.
    cyc(0, 0, 0, 0, 0, '0, '0);
    cyc(0, 0, 0, 0, 0, '0, '0);
    chk("reset_addr", ireq_addr, PCR);

    // Back-to-back stream: one request every third cycle.
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 0) begin
        chk("stream_req", {63'd0, ireq_valid}, 64'd1);
        chk("stream_addr", ireq_addr, PCR + 64'(4 * (i / 3)));
      end
      cyc(1, 1, (q.size() > 0), 1, 0, '0, $urandom);
    end

    // Decode stalls five cycles in HOLD.
    cyc(1, 1, 0, 0, 0, '0, '0);
    cyc(1, 0, 1, 0, 0, '0, 32'hCAFE_0001);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 0, 0, '0, '0);
      chk("stall_instr", {32'd0, instr}, 64'hCAFE_0001);
      chk("stall_pc", instr_pc, PCR + 64'hC);
    end
    cyc(1, 0, 0, 1, 0, '0, '0);
    chk("stall_release", {63'd0, ireq_valid}, 64'd1);

    // Redirect in WAIT: stale data never presented.
    cyc(1, 1, 0, 0, 0, '0, '0);
    cyc(1, 0, 0, 0, 1, 64'h8000_0100, '0);
    cyc(1, 0, 1, 0, 0, '0, 32'h0000_0013);
    chk("drop_valid", {63'd0, instr_valid}, 64'd0);
    chk("drop_addr", ireq_addr, 64'h8000_0100);

    // Redirect in HOLD together with ready; low address bits ignored.
    cyc(1, 1, 0, 0, 0, '0, '0);
    cyc(1, 0, 1, 0, 0, '0, 32'h1234_5678);
    cyc(1, 0, 0, 1, 1, 64'h8000_0203, '0);
    chk("hold_redir_valid", {63'd0, instr_valid}, 64'd0);
    chk("hold_redir_addr", ireq_addr, 64'h8000_0200);

    // Redirect in REQ before acceptance.
    cyc(1, 0, 0, 0, 0, '0, '0);
    cyc(1, 0, 0, 0, 1, 64'h8000_0400, '0);
    chk("req_redir_addr", ireq_addr, 64'h8000_0400);
    cyc(1, 0, 0, 0, 0, '0, '0);
    cyc(1, 1, 0, 0, 0, '0, '0);
    cyc(1, 0, 1, 0, 0, '0, 32'hABCD_0000);
    chk("req_redir_pc", instr_pc, 64'h8000_0400);
    cyc(1, 0, 0, 1, 0, '0, '0);

    // PC wrap from the top of the address space.
    cyc(1, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, '0);
    cyc(1, 1, 0, 0, 0, '0, '0);
    cyc(1, 0, 1, 0, 0, '0, 32'h0000_006F);
    chk("wrap_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(1, 0, 0, 1, 0, '0, '0);
    chk("wrap_addr", ireq_addr, 64'd0);

    // Randomised traffic, including occasional mid-transaction reset.
    for (int i = 0; i < 2000; i++) begin
      rn  = ($urandom % 256) != 0;
      a   = ($urandom % 3) != 0;
      d   = (q.size() > 0) && (($urandom % 2) != 0);
      r   = ($urandom % 3) != 0;
      rv  = ($urandom % 10) == 0;
      rpc = (($urandom % 4) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom % 16))
                                  : {32'd0, $urandom};
      cyc(rn, a, d, r, rv, rpc, $urandom);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch stage feeding the instruction decoder. It owns the program counter, issues single-outstanding word reads on the instruction bus, and presents each fetched 32-bit instruction with its PC to decode over a valid/ready handshake. It accepts PC redirects from execute, covering taken branches, `jal` and `jalr`. A redirect flushes any in-flight or held instruction.

## Interface
- `XLEN`, default 64: PC width.
- `PC_RESET`, default 64'h8000_0000: first fetch address.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-low; one clock; `reset`=0 sampled on a `clk` edge resets the block.
- `ireq_valid`  out  1: bus read request.
- `ireq_addr`  out  XLEN: word-aligned fetch address.
- `ireq_addr_ok`  in  1: bus accepted the address this cycle.
- `iresp_data_ok`  in  1: read data valid this cycle.
- `iresp_data`  in  32: read data.
- `instr_valid`  out  1: instruction available to decode.
- `instr`  out  32: instruction word.
- `instr_pc`  out  XLEN: PC of `instr`.
- `instr_ready`  in  1: decode accepts `instr` this cycle.
- `redirect_valid`  in  1: execute requests a PC change.
- `redirect_pc`  in  XLEN: new PC; bits [1:0] are ignored and treated as 0.

## Operation
- State machine `REQ`, `WAIT`, `HOLD`, `DROP`. Registers: `pc`, output buffer (`instr`, `instr_pc`, `instr_valid`).
- Reset values: state=`REQ`, `pc`=`PC_RESET`, `instr_valid`=0, `instr`=0, `instr_pc`=0. `ireq_valid` and `ireq_addr` are combinational from state and `pc`, so they read 1 / `PC_RESET` on the first cycle after reset.
- `REQ`: `ireq_valid`=1, `ireq_addr`=`pc`.
  - `ireq_addr_ok` → `WAIT`.
  - `redirect_valid` without `ireq_addr_ok` → `pc`←`redirect_pc`, stay `REQ`. The address may change before acceptance.
  - `redirect_valid` with `ireq_addr_ok` → `pc`←`redirect_pc`, go to `DROP`.
- `WAIT`: `ireq_valid`=0.
  - `iresp_data_ok` without redirect → `instr`←`iresp_data`, `instr_pc`←`pc`, `instr_valid`←1, `pc`←`pc`+4, go to `HOLD`.
  - `redirect_valid` with `iresp_data_ok` → data discarded, `pc`←`redirect_pc`, go to `REQ`.
  - `redirect_valid` without `iresp_data_ok` → `pc`←`redirect_pc`, go to `DROP`.
- `HOLD`: `instr_valid`=1. `instr` and `instr_pc` stay stable until the handshake completes.
  - `instr_ready` → `instr_valid`←0, go to `REQ`.
  - `redirect_valid` (with or without `instr_ready`) → `instr_valid`←0, `pc`←`redirect_pc`, go to `REQ`. When `instr_ready` is also high, decode has taken the instruction.
- `DROP`: `ireq_valid`=0. Waits for the stale response.
  - `iresp_data_ok` → data discarded, go to `REQ`.
  - A further `redirect_valid` overwrites `pc`. If `iresp_data_ok` arrives in the same cycle, go to `REQ`; otherwise stay in `DROP`.
- Redirect has priority over every other event in every state.
- PC arithmetic is modulo 2^XLEN, so `pc`+4 wraps from all-ones to 0.
- Only one request is ever outstanding. `iresp_data_ok` in `REQ` or `HOLD` is a protocol violation: ignore it and assert it in simulation.

## Timing
- Minimum per-instruction cycle is 3: `REQ` (addr_ok) → `WAIT` (data_ok) → `HOLD` (ready). That gives `instr_valid` 2 cycles after the `ireq_valid`/`ireq_addr_ok` handshake cycle when `iresp_data_ok` returns the cycle after acceptance.
- Redirect to first new request: `ireq_valid` with the new address appears the cycle after `redirect_valid` (from `REQ`, `HOLD`, or `WAIT`+data_ok). From `DROP` it appears the cycle after `iresp_data_ok`.
- `instr_valid` falls the cycle after the consuming handshake or the redirect; it never falls without one of these.
- Reset asserted mid-transaction returns the block to `REQ` with `PC_RESET`. A late `iresp_data_ok` from the aborted read is the bus's responsibility to suppress.

## Structure
- Shared package `fetch_pkg`:
  - `typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} fetch_state_t`.
  - `PC_RESET` default.
  - Instruction-width constant `ILEN` = 32.
- Single module, no sub-module; the output buffer is three registers inside `ifu_fetch`.

## Test plan
- Reset release, bus always `addr_ok`=1 and `data_ok` one cycle later, `instr_ready`=1 → addresses 8000_0000, 8000_0004, 8000_0008 issued every 3 cycles; `instr_pc` matches each address.
- `instr_ready`=0 for 5 cycles in `HOLD` → `instr` and `instr_pc` stable, `ireq_valid`=0 throughout; one new request the cycle after ready.
- Redirect to 8000_0100 while in `WAIT` → state `DROP`; returned data 0x0000_0013 is never presented; next request address is 8000_0100.
- Redirect to 8000_0203 in `HOLD` together with `instr_ready` → `instr_valid` drops next cycle; next `ireq_addr` is 8000_0200.
- Redirect while in `REQ` with `addr_ok` held low 3 cycles → `ireq_addr` switches to the redirect target before acceptance; no `DROP` entered.
- `pc` = FFFF_FFFF_FFFF_FFFC fetch completes → next `ireq_addr` is 0.
